io_port_bank: RTL
=================

IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N_PORTS, default 8, giving the number of ports (1..16).
REQ-002 The block SHALL have parameter DW, default 8, giving the port and data width in bits.
REQ-003 The block SHALL have parameter AW, default 8, giving the address width in bits.
REQ-004 The block SHALL have parameter BASE, default 0, giving the first mapped address.

Ports (name, direction, width, meaning):
REQ-005 The port list SHALL be, in order:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- addr, in, AW: CPU address.
- RE, in, 1: read strobe, one cycle.
- WE, in, 1: write strobe, one cycle.
- Din, in, DW: write data.
- Dout, out, DW: read data, registered.
- rd_valid, out, 1: Dout valid, registered.
- io_read, out, 1: combinational; high when RE is high and addr hits the map.
- io_write, out, 1: combinational; high when WE is high and addr hits the map.
- pins_i, in, N_PORTS*DW: raw pad inputs; port k occupies bits [k*DW +: DW].
- pins_o, out, N_PORTS*DW: pad output values.
- pins_oe, out, N_PORTS*DW: per-bit output enables.
- irq, out, 1: interrupt request.

Function
REQ-006 The block SHALL decode this register map, with offset = addr - BASE and k = port index:
- DATA[k] at offset k.
- DIR[k] at offset N_PORTS+k.
- STAT[k] at offset 2*N_PORTS+k, present only when the macro is defined.
REQ-007 An address "hits" when the offset falls inside the map; the comparison SHALL be unsigned in AW bits, with no wrap-around aliasing past 2^AW-1.
REQ-008 Each pad input SHALL pass through a 2-flop synchroniser; the "synced" value is the second-stage output.
REQ-009 A write with WE high on a hit SHALL update the addressed DATA_OUT[k] or DIR[k] register from Din at the next clk edge.
REQ-010 A write to an unmapped address SHALL have no effect.
REQ-011 pins_o port k SHALL equal DATA_OUT[k], and pins_oe port k SHALL equal DIR[k] (bit=1 drives the pad).
REQ-012 A read with RE high SHALL register Dout and raise rd_valid on the next edge, giving latency 1.
REQ-013 rd_valid SHALL be low in every cycle that follows a cycle with RE low.
REQ-014 A DATA[k] read SHALL return (DIR & DATA_OUT) | (~DIR & synced) bitwise.
REQ-015 A DIR[k] read SHALL return DIR[k].
REQ-016 A read of an unmapped address SHALL return 0 with rd_valid high.
REQ-017 When RE and WE are high on the same address in the same cycle, the read SHALL return the pre-write value and the write SHALL take effect.
REQ-018 Dout SHALL hold its last value while rd_valid is low.
REQ-019 Back-to-back reads SHALL be accepted every cycle with no stall.

Reset
REQ-020 rst_n low SHALL asynchronously clear DATA_OUT, DIR, STAT, both synchroniser stages, Dout, rd_valid and irq to 0.
REQ-021 After reset all pads SHALL be inputs (pins_oe = 0).
REQ-022 Reset asserted mid-access SHALL discard the access; the first cycle after release SHALL show rd_valid = 0.
REQ-023 rst_n deassertion SHALL take effect on a clk edge only; the block SHALL accept an externally synchronised release.

Configuration
REQ-024 The macro IO_PORT_IRQ_EN SHALL select the edge-capture feature.
REQ-025 With IO_PORT_IRQ_EN defined:
- The block SHALL keep a per-bit previous-synced register.
- A 0->1 transition of a synced input bit whose DIR bit is 0 SHALL set STAT[k] bit.
- STAT[k] SHALL be writable write-1-to-clear.
- irq SHALL be registered and equal to the OR of all STAT bits.
- A set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-026 Without IO_PORT_IRQ_EN:
- No STAT or previous-synced storage SHALL exist.
- STAT offsets SHALL be unmapped (io_read and io_write low there).
- irq SHALL be tied to 0.

Verification
REQ-027 The bench SHALL cover each directed scenario below:
- Reset, then read DIR[0..N-1] -> all return 0x00; pins_oe = 0.
- Write DIR[2]=0xF0, then DATA[2]=0xA5 -> pins_o port 2 = 0xA5 and pins_oe port 2 = 0xF0; with pins_i port 2 = 0x3C, read DATA[2] -> 0xAC, rd_valid high exactly one cycle after RE.
- Change pins_i port 0 from 0x00 to 0x81 -> DATA[0] reads 0x00 for 2 cycles, then 0x81 from the 3rd edge on.
- With BASE=0x10, AW=8, N_PORTS=8: RE at addr 0x0F and at 0x30 (no macro) -> io_read low, Dout=0x00, rd_valid high; WE at 0x0F changes no register.
- Simultaneous RE+WE at DATA[1] with old 0x11, Din=0x22 -> Dout=0x11; the next read returns 0x22.
- With IO_PORT_IRQ_EN: input bit 3 of port 4 rises -> STAT[4]=0x08 and irq=1; write STAT[4]=0x08 in the same cycle as a new rise on bit 3 -> bit stays set; a later clear with no edge -> irq=0 the next cycle.

Source files
------------

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - memory-mapped GPIO port bank with 2-flop input synchronisers
// Optional edge capture (STAT registers, irq) is built when IO_PORT_IRQ_EN is defined.
module io_port_bank #(
    parameter int N_PORTS = 8,
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int BASE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         addr,
    input  logic                  RE,
    input  logic                  WE,
    input  logic [DW-1:0]         Din,
    output logic [DW-1:0]         Dout,
    output logic                  rd_valid,
    output logic                  io_read,
    output logic                  io_write,
    input  logic [N_PORTS*DW-1:0] pins_i,
    output logic [N_PORTS*DW-1:0] pins_o,
    output logic [N_PORTS*DW-1:0] pins_oe,
    output logic                  irq
);

`ifdef IO_PORT_IRQ_EN
    localparam int N_BANKS = 3;
`else
    localparam int N_BANKS = 2;
`endif
    localparam int            MAP_SIZE = N_BANKS * N_PORTS;
    localparam logic [AW-1:0] BASE_A   = AW'(BASE);

    logic [N_PORTS*DW-1:0] data_out_q, data_out_d;
    logic [N_PORTS*DW-1:0] dir_q, dir_d;
    logic [N_PORTS*DW-1:0] sync1_q, sync1_d;
    logic [N_PORTS*DW-1:0] sync2_q, sync2_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;
`ifdef IO_PORT_IRQ_EN
    logic [N_PORTS*DW-1:0] prev_q, prev_d;
    logic [N_PORTS*DW-1:0] stat_q, stat_d;
    logic                  irq_q, irq_d;
`endif

    logic [AW:0]   diff;
    logic [31:0]   off_w;
    logic          hit;
    logic [DW-1:0] rd_data;

    // One extra bit on the subtraction catches addresses below BASE without wrap aliasing.
    always_comb begin
        diff  = {1'b0, addr} - {1'b0, BASE_A};
        off_w = 32'(diff[AW-1:0]);
        hit   = !diff[AW] && (off_w < 32'(MAP_SIZE));
    end

    assign io_read  = RE && hit;
    assign io_write = WE && hit;

    always_comb begin
        rd_data    = '0;
        data_out_d = data_out_q;
        dir_d      = dir_q;
        sync1_d    = pins_i;
        sync2_d    = sync1_q;
`ifdef IO_PORT_IRQ_EN
        prev_d     = sync2_q;
        stat_d     = stat_q;
`endif
        for (int k = 0; k < N_PORTS; k++) begin
            if (hit && off_w == 32'(k)) begin
                rd_data = (dir_q[k*DW +: DW] & data_out_q[k*DW +: DW])
                        | (~dir_q[k*DW +: DW] & sync2_q[k*DW +: DW]);
                if (WE)
                    data_out_d[k*DW +: DW] = Din;
            end
            if (hit && off_w == 32'(N_PORTS + k)) begin
                rd_data = dir_q[k*DW +: DW];
                if (WE)
                    dir_d[k*DW +: DW] = Din;
            end
`ifdef IO_PORT_IRQ_EN
            if (hit && off_w == 32'(2*N_PORTS + k)) begin
                rd_data = stat_q[k*DW +: DW];
                if (WE)
                    stat_d[k*DW +: DW] = stat_q[k*DW +: DW] & ~Din;
            end
`endif
        end
`ifdef IO_PORT_IRQ_EN
        // Rising edges on input-direction bits are OR'd in last so they win over a clear.
        stat_d = stat_d | (sync2_q & ~prev_q & ~dir_q);
        irq_d  = |stat_d;
`endif
        rd_valid_d = RE;
        dout_d     = RE ? rd_data : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
`ifdef IO_PORT_IRQ_EN
            prev_q     <= '0;
            stat_q     <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
`ifdef IO_PORT_IRQ_EN
            prev_q     <= prev_d;
            stat_q     <= stat_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign Dout     = dout_q;
    assign rd_valid = rd_valid_q;
    assign pins_o   = data_out_q;
    assign pins_oe  = dir_q;
`ifdef IO_PORT_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
